// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared types and defaults for the pipelined adder.
// Provides op_e, default sizes and the WIDTH/STAGES legality check.
package pipe_adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam int WIDTH_DEF  = 64;
   localparam int STAGES_DEF = 4;

   function automatic logic width_ok(int w, int s);
      return (s >= 1) && (s <= w) && ((w % s) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// pipe_adder_stage: one registered CW-bit chunk of the carry chain.
// Ports: clk, rst_n, en, a, b, cin -> sum, cout, ovf (+ zin/zout with
// PIPE_ADDER_ZERO_FLAG_EN).
module pipe_adder_stage #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
`ifdef PIPE_ADDER_ZERO_FLAG_EN
   input  logic          zin,
   output logic          zout,
`endif
   output logic [CW-1:0] sum,
   output logic          cout,
   output logic          ovf
);

   logic [CW:0] full;
   logic        c_msb;

   always_comb begin
      full  = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
      // carry into the top bit of this chunk
      c_msb = full[CW-1] ^ a[CW-1] ^ b[CW-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
`ifdef PIPE_ADDER_ZERO_FLAG_EN
         zout <= 1'b0;
`endif
      end else if (en) begin
         sum  <= full[CW-1:0];
         cout <= full[CW];
         ovf  <= c_msb ^ full[CW];
`ifdef PIPE_ADDER_ZERO_FLAG_EN
         zout <= zin & ~|full[CW-1:0];
`endif
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/sub split into STAGES registered carry chunks
// with valid/ready on both sides. Optional o_zero: PIPE_ADDER_ZERO_FLAG_EN.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STAGES = STAGES_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry_in,
   input  op_e              i_op,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_c,
   output logic             o_carry_out,
`ifdef PIPE_ADDER_ZERO_FLAG_EN
   output logic             o_zero,
`endif
   output logic             o_overflow
);

   localparam int CW = WIDTH / STAGES;

   if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a multiple of STAGES");
   end

   logic              adv;
   logic [STAGES-1:0] v;
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;

   logic [CW-1:0] a_s    [STAGES];
   logic [CW-1:0] b_s    [STAGES];
   logic          cin_s  [STAGES];
   logic [CW-1:0] sum_s  [STAGES];
   logic          cout_s [STAGES];
   logic          ovf_s  [STAGES];
`ifdef PIPE_ADDER_ZERO_FLAG_EN
   logic          zin_s  [STAGES];
   logic          zout_s [STAGES];
`endif

   assign b_eff   = (i_op == OP_SUB) ? ~i_b : i_b;
   assign cin_eff = i_carry_in ^ (i_op == OP_SUB);

   // whole pipe moves together; bubbles are kept
   assign adv     = ~v[STAGES-1] | i_ready;
   assign o_ready = adv;
   assign o_valid = v[STAGES-1];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v <= '0;
      end else if (adv) begin
         v[0] <= i_valid;
         for (int k = 1; k < STAGES; k++) begin
            v[k] <= v[k-1];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int UW = WIDTH - (k + 1) * CW;

      // result chunks 0..k, aligned with this stage
      logic [(k+1)*CW-1:0] res;

      if (k == 0) begin : g_in
         assign a_s[k]   = i_a[CW-1:0];
         assign b_s[k]   = b_eff[CW-1:0];
         assign cin_s[k] = cin_eff;
`ifdef PIPE_ADDER_ZERO_FLAG_EN
         assign zin_s[k] = 1'b1;
`endif
         assign res = sum_s[k];
      end else begin : g_in
         logic [k*CW-1:0] lo;

         assign a_s[k]   = g_st[k-1].g_up.a_up[CW-1:0];
         assign b_s[k]   = g_st[k-1].g_up.b_up[CW-1:0];
         assign cin_s[k] = cout_s[k-1];
`ifdef PIPE_ADDER_ZERO_FLAG_EN
         assign zin_s[k] = zout_s[k-1];
`endif

         // skew register for the already-finished low chunks
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               lo <= '0;
            end else if (adv) begin
               lo <= g_st[k-1].res;
            end
         end

         assign res = {sum_s[k], lo};
      end

      if (k < STAGES - 1) begin : g_up
         logic [UW-1:0] a_up;
         logic [UW-1:0] b_up;
         logic [UW-1:0] a_nx;
         logic [UW-1:0] b_nx;

         if (k == 0) begin : g_src
            assign a_nx = i_a[WIDTH-1:CW];
            assign b_nx = b_eff[WIDTH-1:CW];
         end else begin : g_src
            assign a_nx = g_st[k-1].g_up.a_up[WIDTH-k*CW-1:CW];
            assign b_nx = g_st[k-1].g_up.b_up[WIDTH-k*CW-1:CW];
         end

         // operand chunks not yet consumed
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               a_up <= '0;
               b_up <= '0;
            end else if (adv) begin
               a_up <= a_nx;
               b_up <= b_nx;
            end
         end
      end

      pipe_adder_stage #(
         .CW (CW)
      ) u_stage (
         .clk   (i_clk),
         .rst_n (i_rst_n),
         .en    (adv),
         .a     (a_s[k]),
         .b     (b_s[k]),
         .cin   (cin_s[k]),
`ifdef PIPE_ADDER_ZERO_FLAG_EN
         .zin   (zin_s[k]),
         .zout  (zout_s[k]),
`endif
         .sum   (sum_s[k]),
         .cout  (cout_s[k]),
         .ovf   (ovf_s[k])
      );
   end

   assign o_c         = g_st[STAGES-1].res;
   assign o_carry_out = cout_s[STAGES-1];
   assign o_overflow  = ovf_s[STAGES-1];
`ifdef PIPE_ADDER_ZERO_FLAG_EN
   assign o_zero      = zout_s[STAGES-1];
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: self-checking bench for pipe_adder (WIDTH=64, STAGES=4).
// Directed vectors, random stream with backpressure, stall and reset cases.
module tb_pipe_adder;
   import pipe_adder_pkg::*;

   localparam int W = 64;
   localparam int S = 4;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         i_carry_in;
   op_e          i_op;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_c;
   logic         o_carry_out;
   logic         o_overflow;
`ifdef PIPE_ADDER_ZERO_FLAG_EN
   logic         o_zero;
`endif

   int errors = 0;
   int checks = 0;

   pipe_adder #(
      .WIDTH  (W),
      .STAGES (S)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_a         (i_a),
      .i_b         (i_b),
      .i_carry_in  (i_carry_in),
      .i_op        (i_op),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_c         (o_c),
      .o_carry_out (o_carry_out),
`ifdef PIPE_ADDER_ZERO_FLAG_EN
      .o_zero      (o_zero),
`endif
      .o_overflow  (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // reference: {overflow, carry, result} from plain W+1-bit arithmetic
   function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b,
                                          logic cin, op_e op);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         ci;
      logic         ovf;
      bb   = (op == OP_SUB) ? ~b : b;
      ci   = cin ^ (op == OP_SUB);
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
      ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return {ovf, full[W], full[W-1:0]};
   endfunction

   logic [W-1:0] d_a [7] = '{
      64'h5555_5555_5555_5555, 64'h5555_5555_5555_5556,
      64'hffff_ffff_ffff_ffff, 64'h7fff_ffff_ffff_ffff,
      64'h0, 64'd10, 64'h8000_0000_0000_0000};
   logic [W-1:0] d_b [7] = '{
      64'haaaa_aaaa_aaaa_aaaa, 64'haaaa_aaaa_aaaa_aaaa,
      64'hffff_ffff_ffff_ffff, 64'h7fff_ffff_ffff_ffff,
      64'h1, 64'd3, 64'h1};
   logic         d_ci [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic         d_op [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [W-1:0] d_c  [7] = '{
      64'hffff_ffff_ffff_ffff, 64'h0,
      64'hffff_ffff_ffff_fffe, 64'hffff_ffff_ffff_fffe,
      64'hffff_ffff_ffff_ffff, 64'd6, 64'h7fff_ffff_ffff_ffff};
   logic         d_co [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   logic         d_ov [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   task automatic test_reset();
      i_rst_n    = 1'b0;
      i_valid    = 1'b0;
      i_ready    = 1'b1;
      i_a        = '0;
      i_b        = '0;
      i_carry_in = 1'b0;
      i_op       = OP_ADD;
      repeat (3) @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0)
         $display("FAIL reset_valid: got %b expected 0", o_valid);
      if (o_valid !== 1'b0) errors++;
      checks++;
      if (o_c !== '0) begin
         $display("FAIL reset_c: got %h expected 0", o_c);
         errors++;
      end
      checks++;
      if ({o_carry_out, o_overflow} !== 2'b00) begin
         $display("FAIL reset_flags: got %b expected 00",
                  {o_carry_out, o_overflow});
         errors++;
      end
`ifdef PIPE_ADDER_ZERO_FLAG_EN
      checks++;
      if (o_zero !== 1'b0) begin
         $display("FAIL reset_zero: got %b expected 0", o_zero);
         errors++;
      end
`endif
      i_rst_n = 1'b1;
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
         $display("FAIL reset_ready: got %b expected 1", o_ready);
         errors++;
      end
   endtask

   task automatic test_directed();
      int n;
      for (int i = 0; i < 7; i++) begin
         @(negedge i_clk);
         i_valid    = 1'b1;
         i_ready    = 1'b1;
         i_a        = d_a[i];
         i_b        = d_b[i];
         i_carry_in = d_ci[i];
         i_op       = op_e'(d_op[i]);
         @(negedge i_clk);
         i_valid = 1'b0;
         n = 1;
         while (!o_valid && n < 20) begin
            @(negedge i_clk);
            n++;
         end
         checks++;
         if (n !== S) begin
            $display("FAIL dir%0d_latency: got %0d expected %0d", i, n, S);
            errors++;
         end
         checks++;
         if (o_c !== d_c[i]) begin
            $display("FAIL dir%0d_c: got %h expected %h", i, o_c, d_c[i]);
            errors++;
         end
         checks++;
         if (o_carry_out !== d_co[i]) begin
            $display("FAIL dir%0d_carry: got %b expected %b",
                     i, o_carry_out, d_co[i]);
            errors++;
         end
         checks++;
         if (o_overflow !== d_ov[i]) begin
            $display("FAIL dir%0d_ovf: got %b expected %b",
                     i, o_overflow, d_ov[i]);
            errors++;
         end
`ifdef PIPE_ADDER_ZERO_FLAG_EN
         checks++;
         if (o_zero !== (d_c[i] == '0)) begin
            $display("FAIL dir%0d_zero: got %b expected %b",
                     i, o_zero, (d_c[i] == '0));
            errors++;
         end
`endif
      end
   endtask

   task automatic test_random();
      logic [W+1:0] q[$];
      logic [W+1:0] e;
      logic         pend;
      int           sent;
      int           got;
      pend = 1'b0;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
         @(negedge i_clk);
         i_ready = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            if (sent < 40 && $urandom_range(0, 3) != 0) begin
               i_valid    = 1'b1;
               i_a        = {$urandom, $urandom};
               i_b        = ($urandom_range(0, 5) == 0) ? ~i_a :
                            {$urandom, $urandom};
               i_carry_in = 1'($urandom_range(0, 1));
               i_op       = op_e'($urandom_range(0, 1));
            end else begin
               i_valid = 1'b0;
            end
         end
         #1;
         checks++;
         if (o_ready !== (!o_valid || i_ready)) begin
            $display("FAIL rnd_ready: got %b expected %b",
                     o_ready, (!o_valid || i_ready));
            errors++;
         end
         if (o_valid && i_ready) begin
            checks++;
            if (q.size() == 0) begin
               $display("FAIL rnd_spurious: got valid %h expected none", o_c);
               errors++;
            end else begin
               e = q.pop_front();
               if ({o_overflow, o_carry_out, o_c} !== e) begin
                  $display("FAIL rnd_result%0d: got %h expected %h",
                           got, {o_overflow, o_carry_out, o_c}, e);
                  errors++;
               end
`ifdef PIPE_ADDER_ZERO_FLAG_EN
               checks++;
               if (o_zero !== (e[W-1:0] == '0)) begin
                  $display("FAIL rnd_zero%0d: got %b expected %b",
                           got, o_zero, (e[W-1:0] == '0));
                  errors++;
               end
`endif
            end
            got++;
         end
         if (i_valid && o_ready) begin
            q.push_back(model(i_a, i_b, i_carry_in, i_op));
            sent++;
            pend = 1'b0;
         end else begin
            pend = i_valid;
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      checks++;
      if (got !== 40) begin
         $display("FAIL rnd_count: got %0d expected 40", got);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      int           sent;
      int           got;
      int           stalls;
      int           cycles;
      logic [W-1:0] e;
      sent   = 0;
      got    = 0;
      stalls = 0;
      cycles = 0;
      @(negedge i_clk);
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         if (cyc != 0) @(negedge i_clk);
         cycles     = cyc + 1;
         i_ready    = !(cyc >= 6 && cyc <= 8);
         i_valid    = (sent < 8);
         i_a        = W'(sent);
         i_b        = W'(sent);
         i_carry_in = 1'b0;
         i_op       = OP_ADD;
         #1;
         e = W'(2 * got);
         if (!i_ready && o_valid) begin
            stalls++;
            checks++;
            if (o_ready !== 1'b0) begin
               $display("FAIL b2b_stall_ready: got %b expected 0", o_ready);
               errors++;
            end
            checks++;
            if (o_c !== e) begin
               $display("FAIL b2b_stall_c: got %h expected %h", o_c, e);
               errors++;
            end
         end
         if (o_valid && i_ready) begin
            checks++;
            if (o_c !== e) begin
               $display("FAIL b2b_res%0d: got %h expected %h", got, o_c, e);
               errors++;
            end
            got++;
         end
         if (i_valid && o_ready) sent++;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      checks++;
      if (got !== 8 || stalls !== 3) begin
         $display("FAIL b2b_count: got %0d/%0d expected 8/3", got, stalls);
         errors++;
      end
      // 8 results, latency 4, 3 stall cycles: last drain in cycle 15
      checks++;
      if (cycles !== 15) begin
         $display("FAIL b2b_cycles: got %0d expected 15", cycles);
         errors++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         checks++;
         if (o_valid !== 1'b0) begin
            $display("FAIL b2b_extra: got valid %h expected none", o_c);
            errors++;
         end
      end
   endtask

   task automatic test_mid_reset();
      int n;
      for (int i = 1; i <= 4; i++) begin
         @(negedge i_clk);
         i_valid    = 1'b1;
         i_ready    = 1'b1;
         i_a        = W'(100 * i);
         i_b        = W'(7);
         i_carry_in = 1'b0;
         i_op       = OP_ADD;
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_c !== W'(107)) begin
         $display("FAIL mr_pre: got %b/%h expected 1/%h", o_valid, o_c,
                  W'(107));
         errors++;
      end
      #1 i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin
         $display("FAIL mr_valid: got %b expected 0", o_valid);
         errors++;
      end
      checks++;
      if ({o_c, o_carry_out, o_overflow} !== '0) begin
         $display("FAIL mr_data: got %h expected 0", o_c);
         errors++;
      end
      #5 i_rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         checks++;
         if (o_valid !== 1'b0) begin
            $display("FAIL mr_stale: got valid %h expected none", o_c);
            errors++;
         end
      end
      i_valid = 1'b1;
      i_a     = W'(1);
      i_b     = W'(1);
      @(negedge i_clk);
      i_valid = 1'b0;
      n = 1;
      while (!o_valid && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      checks++;
      if (n !== S || o_c !== W'(2)) begin
         $display("FAIL mr_after: got lat %0d c %h expected lat %0d c 2",
                  n, o_c, S);
         errors++;
      end
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b0) begin
         $display("FAIL mr_dup: got valid %h expected none", o_c);
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
